// File: rtl/simple_cpu_pkg.sv
// Shared opcodes, FSM states and instruction-field helpers for the parametrised accumulator CPU.
package simple_cpu_pkg;

  localparam int unsigned OPCODE_W   = 4;
  localparam int unsigned MAX_ADDR_W = 16;
  localparam int unsigned MAX_WORD_W = OPCODE_W + MAX_ADDR_W;

  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t OP_NOP = 4'h0;
  localparam opcode_t OP_LDI = 4'h1;
  localparam opcode_t OP_LD  = 4'h2;
  localparam opcode_t OP_ST  = 4'h3;
  localparam opcode_t OP_ADD = 4'h4;
  localparam opcode_t OP_SUB = 4'h5;
  localparam opcode_t OP_AND = 4'h6;
  localparam opcode_t OP_OR  = 4'h7;
  localparam opcode_t OP_XOR = 4'h8;
  localparam opcode_t OP_JMP = 4'h9;
  localparam opcode_t OP_JZ  = 4'hA;
  localparam opcode_t OP_JC  = 4'hB;
  localparam opcode_t OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_t;

  // Instruction words are {opcode, operand}; callers zero-extend them to MAX_WORD_W.
  function automatic opcode_t op_field(input logic [MAX_WORD_W-1:0] word,
                                       input int unsigned addr_w);
    return word[addr_w +: OPCODE_W];
  endfunction

  function automatic logic [MAX_ADDR_W-1:0] operand_field(input logic [MAX_WORD_W-1:0] word,
                                                          input int unsigned addr_w);
    return word[MAX_ADDR_W-1:0] & MAX_ADDR_W'((32'd1 << addr_w) - 32'd1);
  endfunction

  function automatic logic writes_acc(input opcode_t op);
    return op inside {OP_LDI, OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
  endfunction

  function automatic logic is_logic_op(input opcode_t op);
    return op inside {OP_AND, OP_OR, OP_XOR};
  endfunction

endpackage

// File: rtl/simple_cpu_param_if.sv
// Program-load bus: the loader (master) writes instruction words into program memory.
interface simple_cpu_param_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [ADDR_W+3:0] prog_data;

  modport master (output prog_we, prog_addr, prog_data);
  modport slave  (input  prog_we, prog_addr, prog_data);
endinterface

// File: rtl/simple_cpu_alu.sv
// Combinational datapath: produces the accumulator candidate plus carry/borrow and zero.
module simple_cpu_alu
  import simple_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  opcode_t           opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [ADDR_W-1:0] operand,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] wide;

  // Bit DATA_W of the widened result is carry-out for ADD and borrow for SUB.
  always_comb begin
    wide = '0;
    case (opcode)
      OP_LDI:  wide = {1'b0, DATA_W'(operand)};
      OP_LD:   wide = {1'b0, mem_data};
      OP_ADD:  wide = {1'b0, acc} + {1'b0, mem_data};
      OP_SUB:  wide = {1'b0, acc} - {1'b0, mem_data};
      OP_AND:  wide = {1'b0, acc & mem_data};
      OP_OR:   wide = {1'b0, acc | mem_data};
      OP_XOR:  wide = {1'b0, acc ^ mem_data};
      default: wide = {1'b0, acc};
    endcase
    result = wide[DATA_W-1:0];
    carry  = wide[DATA_W];
    zero   = (wide[DATA_W-1:0] == '0);
  end

endmodule

// File: rtl/simple_cpu_param.sv
// Multi-cycle accumulator CPU with writable program/data memories and a debug read port.
// Define SIMPLE_CPU_BRANCH_EN to implement JZ/JC; otherwise those opcodes execute as NOP.
module simple_cpu_param
  import simple_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  simple_cpu_param_if.slave   prog,
  input  logic [ADDR_W-1:0]   memory_address,
  output logic [DATA_W-1:0]   data_out,
  output logic [ADDR_W-1:0]   pc,
  output logic [DATA_W-1:0]   acc,
  output logic                busy,
  output logic                halted
);

  localparam int unsigned INSTR_W = OPCODE_W + ADDR_W;
  localparam int unsigned DEPTH   = 1 << ADDR_W;

  logic [INSTR_W-1:0] prog_mem [DEPTH];
  logic [DATA_W-1:0]  data_mem [DEPTH];

  state_t             state;
  logic [INSTR_W-1:0] ir;
  opcode_t            opcode;
  logic [ADDR_W-1:0]  operand;
  logic [DATA_W-1:0]  mdr;
  logic               zf;
  logic               cf;

  logic [DATA_W-1:0]  alu_result;
  logic               alu_carry;
  logic               alu_zero;
  logic               take_jump;

  simple_cpu_alu #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_alu (
    .opcode   (opcode),
    .acc      (acc),
    .mem_data (mdr),
    .operand  (operand),
    .result   (alu_result),
    .carry    (alu_carry),
    .zero     (alu_zero)
  );

`ifdef SIMPLE_CPU_BRANCH_EN
  assign take_jump = (opcode == OP_JMP) || (opcode == OP_JZ && zf) || (opcode == OP_JC && cf);
`else
  assign take_jump = (opcode == OP_JMP);
`endif

  assign data_out = data_mem[memory_address];

  // Sequencer: each instruction walks FETCH -> DECODE -> EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      pc      <= '0;
      acc     <= '0;
      zf      <= 1'b0;
      cf      <= 1'b0;
      ir      <= '0;
      opcode  <= OP_NOP;
      operand <= '0;
      mdr     <= '0;
      busy    <= 1'b0;
      halted  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        prog_mem[ADDR_W'(i)] <= '0;
        data_mem[ADDR_W'(i)] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (prog.prog_we) prog_mem[prog.prog_addr] <= prog.prog_data;
          if (run) begin
            state  <= ST_FETCH;
            pc     <= '0;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        ST_FETCH: begin
          ir    <= prog_mem[pc];
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          opcode  <= op_field(MAX_WORD_W'(ir), ADDR_W);
          operand <= ADDR_W'(operand_field(MAX_WORD_W'(ir), ADDR_W));
          mdr     <= data_mem[ADDR_W'(operand_field(MAX_WORD_W'(ir), ADDR_W))];
          state   <= ST_EXEC;
        end
        ST_EXEC: begin
          if (writes_acc(opcode)) begin
            acc <= alu_result;
            zf  <= alu_zero;
          end
          if (opcode == OP_ADD || opcode == OP_SUB) cf <= alu_carry;
          else if (is_logic_op(opcode))             cf <= 1'b0;
          if (opcode == OP_ST) data_mem[operand] <= acc;
          // HLT parks pc on itself so a debugger sees where execution stopped.
          if (opcode == OP_HLT) begin
            state  <= ST_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= ST_FETCH;
            pc    <= take_jump ? operand : pc + ADDR_W'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_cpu_param.sv
// Bench for simple_cpu_param: 8-bit and 4-bit data builds run identical programs side by side.
module tb_simple_cpu_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic [3:0] memory_address = '0;

  logic [7:0] data_out8, acc8;
  logic [3:0] data_out4, acc4, pc8, pc4;
  logic       busy8, busy4, halted8, halted4;

  int tests  = 0;
  int failed = 0;

  simple_cpu_param_if #(.ADDR_W(4)) pbus ();

  simple_cpu_param #(.DATA_W(8), .ADDR_W(4)) u8 (
    .clk(clk), .reset(reset), .run(run), .prog(pbus),
    .memory_address(memory_address), .data_out(data_out8),
    .pc(pc8), .acc(acc8), .busy(busy8), .halted(halted8)
  );

  simple_cpu_param #(.DATA_W(4), .ADDR_W(4)) u4 (
    .clk(clk), .reset(reset), .run(run), .prog(pbus),
    .memory_address(memory_address), .data_out(data_out4),
    .pc(pc4), .acc(acc4), .busy(busy4), .halted(halted4)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [0:7][7:0] prog;
    int              n_instr;
    logic [3:0]      pc;
    logic [7:0]      acc8;
    logic            c8, z8;
    logic [3:0]      acc4;
    logic            c4, z4;
    logic [3:0]      maddr;
    logic [7:0]      m8;
    logic [3:0]      m4;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];
  vec_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pbus.prog_we = 1'b0;
    run   = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
    pbus.prog_we   = 1'b1;
    pbus.prog_addr = a;
    pbus.prog_data = d;
    tick();
    pbus.prog_we   = 1'b0;
  endtask

  task automatic start_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_halt(output int cyc);
    cyc = 0;
    while (!halted8 && cyc < 300) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    vec_t e;
    int   cyc;

    pbus.prog_we   = 1'b0;
    pbus.prog_addr = '0;
    pbus.prog_data = '0;

    vecs[0] = '{name:"add8", prog:{8'h1F,8'h32,8'h42,8'h33,8'hF0,8'h00,8'h00,8'h00}, n_instr:5, pc:4'd4,
                acc8:8'h1E, c8:0, z8:0, acc4:4'hE, c4:1, z4:0, maddr:4'd3, m8:8'h1E, m4:4'hE};
    vecs[1] = '{name:"carry", prog:{8'h1F,8'h30,8'h40,8'hF0,8'h00,8'h00,8'h00,8'h00}, n_instr:4, pc:4'd3,
                acc8:8'h1E, c8:0, z8:0, acc4:4'hE, c4:1, z4:0, maddr:4'd0, m8:8'h0F, m4:4'hF};
    vecs[2] = '{name:"sub", prog:{8'h1F,8'h30,8'h10,8'h50,8'hF0,8'h00,8'h00,8'h00}, n_instr:5, pc:4'd4,
                acc8:8'hF1, c8:1, z8:0, acc4:4'h1, c4:1, z4:0, maddr:4'd0, m8:8'h0F, m4:4'hF};
`ifdef SIMPLE_CPU_BRANCH_EN
    vecs[3] = '{name:"branch", prog:{8'h10,8'hA5,8'h11,8'hF0,8'h00,8'h37,8'hF0,8'h00}, n_instr:4, pc:4'd6,
                acc8:8'h00, c8:0, z8:1, acc4:4'h0, c4:0, z4:1, maddr:4'd7, m8:8'h00, m4:4'h0};
`else
    vecs[3] = '{name:"branch", prog:{8'h10,8'hA5,8'h11,8'hF0,8'h00,8'h37,8'hF0,8'h00}, n_instr:4, pc:4'd3,
                acc8:8'h01, c8:0, z8:0, acc4:4'h1, c4:0, z4:0, maddr:4'd7, m8:8'h00, m4:4'h0};
`endif
    vecs[4] = '{name:"logic", prog:{8'h1C,8'h31,8'h1A,8'h81,8'h32,8'h21,8'h72,8'hF0}, n_instr:8, pc:4'd7,
                acc8:8'h0E, c8:0, z8:0, acc4:4'hE, c4:0, z4:0, maddr:4'd2, m8:8'h06, m4:4'h6};
    vecs[5] = '{name:"andclr", prog:{8'h1F,8'h30,8'h40,8'h60,8'hF0,8'h00,8'h00,8'h00}, n_instr:5, pc:4'd4,
                acc8:8'h0E, c8:0, z8:0, acc4:4'hE, c4:0, z4:0, maddr:4'd0, m8:8'h0F, m4:4'hF};
    vecs[6] = '{name:"xorzero", prog:{8'h19,8'h34,8'h84,8'hF0,8'h00,8'h00,8'h00,8'h00}, n_instr:4, pc:4'd3,
                acc8:8'h00, c8:0, z8:1, acc4:4'h0, c4:0, z4:1, maddr:4'd4, m8:8'h09, m4:4'h9};

    // Reset state
    do_reset();
    check("rst_pc8", 32'(pc8), 32'd0);
    check("rst_acc8", 32'(acc8), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_halted8", 32'(halted8), 32'd0);
    check("rst_dout8", 32'(data_out8), 32'd0);

    // Table-driven programs, expectations queued at run and retired at halt
    for (int i = 0; i < NV; i++) begin
      do_reset();
      for (int k = 0; k < 8; k++) prog_write(4'(k), vecs[i].prog[k]);
      exp_q.push_back(vecs[i]);
      start_run();
      wait_halt(cyc);
      e = exp_q.pop_front();
      check({e.name, "_halted8"}, 32'(halted8), 32'd1);
      check({e.name, "_halted4"}, 32'(halted4), 32'd1);
      check({e.name, "_cycles"}, 32'(cyc), 32'(3 * e.n_instr));
      check({e.name, "_pc8"}, 32'(pc8), 32'(e.pc));
      check({e.name, "_pc4"}, 32'(pc4), 32'(e.pc));
      check({e.name, "_acc8"}, 32'(acc8), 32'(e.acc8));
      check({e.name, "_acc4"}, 32'(acc4), 32'(e.acc4));
      check({e.name, "_c8"}, 32'(u8.cf), 32'(e.c8));
      check({e.name, "_z8"}, 32'(u8.zf), 32'(e.z8));
      check({e.name, "_c4"}, 32'(u4.cf), 32'(e.c4));
      check({e.name, "_z4"}, 32'(u4.zf), 32'(e.z4));
      memory_address = e.maddr;
      #1;
      check({e.name, "_mem8"}, 32'(data_out8), 32'(e.m8));
      check({e.name, "_mem4"}, 32'(data_out4), 32'(e.m4));
    end

    // PC wrap, plus run and prog_we ignored while busy
    do_reset();
    prog_write(4'd0, 8'h9F);
    start_run();
    prog_write(4'd0, 8'hF0);
    tick();
    tick();
    check("wrap_jmp_pc8", 32'(pc8), 32'd15);
    run = 1'b1;
    tick();
    run = 1'b0;
    check("busy_run_pc8", 32'(pc8), 32'd15);
    check("busy_run_pc4", 32'(pc4), 32'd15);
    tick();
    tick();
    check("wrap_pc8", 32'(pc8), 32'd0);
    check("wrap_pc4", 32'(pc4), 32'd0);
    check("wrap_busy8", 32'(busy8), 32'd1);
    tick();
    tick();
    tick();
    check("busy_we_pc8", 32'(pc8), 32'd15);
    check("busy_we_halted8", 32'(halted8), 32'd0);

    // Write to addr 1 ignored while busy, honoured in HALT together with run
    do_reset();
    prog_write(4'd0, 8'h15);
    prog_write(4'd1, 8'hF0);
    prog_write(4'd2, 8'hF0);
    start_run();
    prog_write(4'd1, 8'h19);
    wait_halt(cyc);
    check("hw1_pc8", 32'(pc8), 32'd1);
    check("hw1_acc8", 32'(acc8), 32'h05);
    pbus.prog_we   = 1'b1;
    pbus.prog_addr = 4'd1;
    pbus.prog_data = 8'h19;
    run            = 1'b1;
    tick();
    pbus.prog_we   = 1'b0;
    run            = 1'b0;
    check("hw2_busy8", 32'(busy8), 32'd1);
    wait_halt(cyc);
    check("hw2_cycles", 32'(cyc), 32'd9);
    check("hw2_pc8", 32'(pc8), 32'd2);
    check("hw2_acc8", 32'(acc8), 32'h09);
    check("hw2_acc4", 32'(acc4), 32'h9);

    // Asynchronous reset while ADD is in EXEC
    do_reset();
    prog_write(4'd0, 8'h1F);
    prog_write(4'd1, 8'h32);
    prog_write(4'd2, 8'h42);
    prog_write(4'd3, 8'hF0);
    start_run();
    for (int k = 0; k < 8; k++) tick();
    check("pre_rst_acc8", 32'(acc8), 32'h0F);
    reset = 1'b0;
    #1;
    check("mid_pc8", 32'(pc8), 32'd0);
    check("mid_acc8", 32'(acc8), 32'd0);
    check("mid_acc4", 32'(acc4), 32'd0);
    check("mid_busy8", 32'(busy8), 32'd0);
    check("mid_halted8", 32'(halted8), 32'd0);
    check("mid_cz8", 32'({u8.cf, u8.zf}), 32'd0);
    for (int a = 0; a < 16; a++) begin
      memory_address = 4'(a);
      #1;
      check($sformatf("mid_dout8_%0d", a), 32'(data_out8), 32'd0);
      check($sformatf("mid_dout4_%0d", a), 32'(data_out4), 32'd0);
    end
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_state8", 32'(u8.state), 32'(simple_cpu_pkg::ST_IDLE));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/simple_cpu_param.md
# simple_cpu_param

Parametrised successor of the 4-bit accumulator CPU: a multi-cycle accumulator machine with configurable data and address width, an on-chip writable program memory and data memory, carry/zero flags, jumps and an explicit halt. It sits under a testbench or SoC wrapper that loads a program, pulses `run`, and inspects data memory through the combinational debug read port (`memory_address` → `data_out`), as the 4-bit CPU does.

## Interface
- `DATA_W`, 8, accumulator/data-memory word width (≥4)
- `ADDR_W`, 4, PC/operand width; program and data memories each hold 2^ADDR_W words
- `clk`  input  1  clock, all state on rising edge
- `reset`  input  1  asynchronous, active-low reset (asserted at 0)
- `run`  input  1  start pulse; honoured only in IDLE or HALT
- `prog_we`  input  1  program-memory write strobe
- `prog_addr`  input  ADDR_W  program write address
- `prog_data`  input  4+ADDR_W  instruction word {opcode[3:0], operand}
- `memory_address`  input  ADDR_W  debug read address into data memory
- `data_out`  output  DATA_W  data_mem[memory_address], combinational
- `pc`  output  ADDR_W  program counter
- `acc`  output  DATA_W  accumulator
- `busy`  output  1  high in FETCH/DECODE/EXEC
- `halted`  output  1  high in HALT

## Operation
- FSM: IDLE → (run) FETCH → DECODE → EXEC → FETCH …; EXEC of HLT → HALT; HALT → (run) FETCH.
- `run` clears `pc` to 0; `acc`, flags and data memory keep their values.
- FETCH: ir ← prog_mem[pc]. DECODE: latch opcode/operand, read data_mem[operand]. EXEC: execute, update pc.
- Opcodes: 0 NOP; 1 LDI acc←zero-extended operand; 2 LD acc←mem[op]; 3 ST mem[op]←acc; 4 ADD acc←acc+mem[op], C←carry-out; 5 SUB acc←acc−mem[op], C←borrow; 6 AND; 7 OR; 8 XOR; 9 JMP pc←op; A JZ; B JC; F HLT; C–E NOP.
- Z updated on every opcode that writes acc (Z = acc_next==0); C updated only by ADD/SUB; logic ops clear C.
- Arithmetic modulo 2^DATA_W; carry is bit DATA_W of the (DATA_W+1)-bit result.
- Non-jump pc ← pc+1 modulo 2^ADDR_W (2^ADDR_W−1 wraps to 0). Taken jump pc ← operand.
- HLT leaves pc pointing at the HLT instruction.
- `prog_we` writes only in IDLE/HALT; ignored while busy.
- `run` while busy ignored; `run` and `prog_we` in the same HALT/IDLE cycle: write happens, then FETCH starts next cycle.

## Timing
- Every instruction takes exactly 3 cycles; N instructions ending in HLT: `halted` rises 3N cycles after the edge that samples `run`.
- ST result visible on `data_out` the cycle after the EXEC edge.
- Reset (any time, including mid-instruction): state IDLE, pc=0, acc=0, Z=0, C=0, both memories cleared to 0, busy=0, halted=0; `data_out`=0.

## Configuration
- `SIMPLE_CPU_BRANCH_EN` defined: JZ (pc←op if Z) and JC (pc←op if C) implemented.
- Not defined: opcodes A and B execute as NOP (pc+1, flags unchanged); JMP always present.

## Structure
- Package `simple_cpu_pkg`: opcode constants, FSM state enum, instruction field extraction helpers.
- One natural sub-module: `simple_cpu_alu` (combinational; opcode, acc, operand data → result, carry, zero).

## Test plan
- Reset mid-EXEC of ADD → next cycle pc=0, acc=0, busy=0, halted=0, data_out=0 at every address.
- DATA_W=8: program LDI 15; ST 2; ADD 2; ST 3; HLT, run → halted 15 cycles later, acc=0x1E, data_out(addr 3)=0x1E, pc=4.
- DATA_W=4: LDI 15; ST 0; ADD 0; HLT → acc=0xE, C=1, Z=0; then SUB path LDI 0; SUB 0 → acc=0x1, C=1.
- With BRANCH_EN: LDI 0; JZ 5; LDI 1; HLT; NOP; ST 7; HLT → mem[7]=0, halts at pc=6; without macro halts at pc=3, acc=1.
- PC wrap (ADDR_W=4): prog_mem[15]=NOP, prog_mem[0]=HLT reached via JMP 15 → halted with pc=0 after wrap.
- prog_we to address 1 while busy → prog_mem unchanged; same write in HALT followed by run → new instruction executed.
